dmi_arb: RTL and testbench

DMI_ARB -- requirements
Module: dmi_arb

---
 rtl/dmi_arb.sv | 169 ++++++++++++++++
 tb/tb_dmi_arb.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmi_arb.sv
// Two-requester round-robin arbiter in front of a single-outstanding DMI port.
// Optional response timeout in WAIT is enabled by defining DMI_ARB_TIMEOUT_EN.
module dmi_arb #(
  parameter int unsigned ADDR_W      = 7,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              dtm_clk,
  input  logic              rst_n,
  input  logic              m0_req_vld,
  output logic              m0_req_rdy,
  input  logic [ADDR_W-1:0] m0_req_addr,
  input  logic [DATA_W-1:0] m0_req_data,
  input  logic [1:0]        m0_req_op,
  output logic              m0_rsp_vld,
  input  logic              m0_rsp_rdy,
  output logic [DATA_W-1:0] m0_rsp_data,
  output logic [1:0]        m0_rsp_op,
  input  logic              m1_req_vld,
  output logic              m1_req_rdy,
  input  logic [ADDR_W-1:0] m1_req_addr,
  input  logic [DATA_W-1:0] m1_req_data,
  input  logic [1:0]        m1_req_op,
  output logic              m1_rsp_vld,
  input  logic              m1_rsp_rdy,
  output logic [DATA_W-1:0] m1_rsp_data,
  output logic [1:0]        m1_rsp_op,
  output logic              dmi_req_vld,
  input  logic              dmi_req_rdy,
  output logic [ADDR_W-1:0] dmi_req_addr,
  output logic [DATA_W-1:0] dmi_req_data,
  output logic [1:0]        dmi_req_op,
  input  logic              dmi_rsp_vld,
  output logic              dmi_rsp_rdy,
  input  logic [DATA_W-1:0] dmi_rsp_data,
  input  logic [1:0]        dmi_rsp_op,
  output logic              busy,
  output logic              owner
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t            state, state_nx;
  logic              last, last_nx;
  logic              owner_q, owner_nx;
  logic              grant;
  logic [ADDR_W-1:0] addr_q, addr_nx;
  logic [DATA_W-1:0] data_q, data_nx;
  logic [1:0]        op_q, op_nx;
  logic [DATA_W-1:0] rdata_q, rdata_nx;
  logic [1:0]        rop_q, rop_nx;

`ifdef DMI_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  logic [CNT_W-1:0] cnt_q, cnt_nx;
`endif

  // On a tie, serve the requester that was not granted last.
  assign grant = (m0_req_vld && m1_req_vld) ? ~last : m1_req_vld;

  always_ff @(posedge dtm_clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      last    <= 1'b1;
      owner_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      op_q    <= '0;
      rdata_q <= '0;
      rop_q   <= '0;
`ifdef DMI_ARB_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state   <= state_nx;
      last    <= last_nx;
      owner_q <= owner_nx;
      addr_q  <= addr_nx;
      data_q  <= data_nx;
      op_q    <= op_nx;
      rdata_q <= rdata_nx;
      rop_q   <= rop_nx;
`ifdef DMI_ARB_TIMEOUT_EN
      cnt_q   <= cnt_nx;
`endif
    end
  end

  always_comb begin
    state_nx   = state;
    last_nx    = last;
    owner_nx   = owner_q;
    addr_nx    = addr_q;
    data_nx    = data_q;
    op_nx      = op_q;
    rdata_nx   = rdata_q;
    rop_nx     = rop_q;
    m0_req_rdy = 1'b0;
    m1_req_rdy = 1'b0;
`ifdef DMI_ARB_TIMEOUT_EN
    cnt_nx     = cnt_q;
`endif
    unique case (state)
      IDLE: begin
        if (m0_req_vld || m1_req_vld) begin
          // rdy is gated by rst_n so no request is consumed while reset is held.
          if (grant) begin
            m1_req_rdy = rst_n;
            addr_nx    = m1_req_addr;
            data_nx    = m1_req_data;
            op_nx      = m1_req_op;
          end else begin
            m0_req_rdy = rst_n;
            addr_nx    = m0_req_addr;
            data_nx    = m0_req_data;
            op_nx      = m0_req_op;
          end
          owner_nx = grant;
          last_nx  = grant;
          state_nx = REQ;
        end
      end
      REQ: begin
        if (dmi_req_rdy) begin
          state_nx = WAIT;
`ifdef DMI_ARB_TIMEOUT_EN
          cnt_nx   = '0;
`endif
        end
      end
      WAIT: begin
        if (dmi_rsp_vld) begin
          rdata_nx = dmi_rsp_data;
          rop_nx   = dmi_rsp_op;
          state_nx = RESP;
        end
`ifdef DMI_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          rdata_nx = '0;
          rop_nx   = 2'b10;
          state_nx = RESP;
        end else begin
          cnt_nx = cnt_q + CNT_W'(1);
        end
`endif
      end
      RESP: begin
        if (owner_q ? m1_rsp_rdy : m0_rsp_rdy) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign dmi_req_vld  = (state == REQ);
  assign dmi_req_addr = addr_q;
  assign dmi_req_data = data_q;
  assign dmi_req_op   = op_q;
  assign dmi_rsp_rdy  = (state != RESP);
  assign busy         = (state != IDLE);
  assign owner        = owner_q;
  assign m0_rsp_vld   = (state == RESP) && !owner_q;
  assign m1_rsp_vld   = (state == RESP) && owner_q;
  assign m0_rsp_data  = rdata_q;
  assign m0_rsp_op    = rop_q;
  assign m1_rsp_data  = rdata_q;
  assign m1_rsp_op    = rop_q;

endmodule

// File: tb/tb_dmi_arb.sv
// Self-checking bench for dmi_arb: table vectors, randomized transactions against
// a transaction-level model, and hand sequences for reset and timeout corners.
module tb_dmi_arb;
  localparam int unsigned AW = 7;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 8;

  logic          dtm_clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          m0_req_vld, m0_req_rdy, m0_rsp_vld, m0_rsp_rdy;
  logic          m1_req_vld, m1_req_rdy, m1_rsp_vld, m1_rsp_rdy;
  logic [AW-1:0] m0_req_addr, m1_req_addr, dmi_req_addr;
  logic [DW-1:0] m0_req_data, m1_req_data, m0_rsp_data, m1_rsp_data;
  logic [DW-1:0] dmi_req_data, dmi_rsp_data;
  logic [1:0]    m0_req_op, m1_req_op, m0_rsp_op, m1_rsp_op, dmi_req_op, dmi_rsp_op;
  logic          dmi_req_vld, dmi_req_rdy, dmi_rsp_vld, dmi_rsp_rdy, busy, owner;

  // Requester model: pending flag and held payload per requester.
  bit            pend[2];
  logic [AW-1:0] paddr[2];
  logic [DW-1:0] pdata[2];
  logic [1:0]    pop[2];
  int            rr_last;
  int            tests = 0;
  int            fails = 0;

  assign m0_req_vld  = pend[0];
  assign m0_req_addr = paddr[0];
  assign m0_req_data = pdata[0];
  assign m0_req_op   = pop[0];
  assign m1_req_vld  = pend[1];
  assign m1_req_addr = paddr[1];
  assign m1_req_data = pdata[1];
  assign m1_req_op   = pop[1];

  always #5 dtm_clk = ~dtm_clk;

  dmi_arb #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .dtm_clk(dtm_clk), .rst_n(rst_n),
    .m0_req_vld(m0_req_vld), .m0_req_rdy(m0_req_rdy), .m0_req_addr(m0_req_addr),
    .m0_req_data(m0_req_data), .m0_req_op(m0_req_op), .m0_rsp_vld(m0_rsp_vld),
    .m0_rsp_rdy(m0_rsp_rdy), .m0_rsp_data(m0_rsp_data), .m0_rsp_op(m0_rsp_op),
    .m1_req_vld(m1_req_vld), .m1_req_rdy(m1_req_rdy), .m1_req_addr(m1_req_addr),
    .m1_req_data(m1_req_data), .m1_req_op(m1_req_op), .m1_rsp_vld(m1_rsp_vld),
    .m1_rsp_rdy(m1_rsp_rdy), .m1_rsp_data(m1_rsp_data), .m1_rsp_op(m1_rsp_op),
    .dmi_req_vld(dmi_req_vld), .dmi_req_rdy(dmi_req_rdy), .dmi_req_addr(dmi_req_addr),
    .dmi_req_data(dmi_req_data), .dmi_req_op(dmi_req_op), .dmi_rsp_vld(dmi_rsp_vld),
    .dmi_rsp_rdy(dmi_rsp_rdy), .dmi_rsp_data(dmi_rsp_data), .dmi_rsp_op(dmi_rsp_op),
    .busy(busy), .owner(owner)
  );

  typedef struct {
    bit            v0, v1;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [1:0]    op;
    int            req_wait, rsp_delay;
    logic [DW-1:0] rd;
    logic [1:0]    ro;
    int            rsp_wait;
    int            exp_owner;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge dtm_clk);
    #1;
  endtask

  task automatic mid;
    @(negedge dtm_clk);
  endtask

  task automatic new_req(input int i);
    pend[i]  = 1'b1;
    paddr[i] = AW'($urandom);
    pdata[i] = $urandom;
    pop[i]   = 2'($urandom_range(0, 3));
  endtask

  // Round-robin rule: tie goes to the requester not granted last.
  function automatic int next_win();
    if (pend[0] && pend[1]) return 1 - rr_last;
    return pend[1] ? 1 : 0;
  endfunction

  task automatic do_reset;
    pend[0] = 0; pend[1] = 0;
    dmi_req_rdy = 0; dmi_rsp_vld = 0; m0_rsp_rdy = 0; m1_rsp_rdy = 0;
    rst_n = 0;
    tick;
    tick;
    mid;
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    chk("rst_dmi_req_vld", dmi_req_vld, 0);
    chk("rst_dmi_req_addr", dmi_req_addr, 0);
    chk("rst_dmi_req_data", dmi_req_data, 0);
    chk("rst_rsp_vld", {m0_rsp_vld, m1_rsp_vld}, 0);
    chk("rst_rsp_data", m0_rsp_data, 0);
    chk("rst_dmi_rsp_rdy", dmi_rsp_rdy, 1);
    rst_n = 1;
    rr_last = 1;
    tick;
  endtask

  // One full transaction; exp_win is the requester that must be granted.
  task automatic run_txn(input int exp_win, input int req_wait, input int rsp_delay,
                         input logic [DW-1:0] rd, input logic [1:0] ro,
                         input int rsp_wait, input bit refill);
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic [1:0]    eo;
    mid;
    chk("idle_busy", busy, 0);
    chk("grant_m0", m0_req_rdy, exp_win == 0);
    chk("grant_m1", m1_req_rdy, exp_win == 1);
    ea = paddr[exp_win]; ed = pdata[exp_win]; eo = pop[exp_win];
    tick;
    pend[exp_win] = 0;
    rr_last = exp_win;
    if (refill) new_req(exp_win);
    for (int i = 0; i <= req_wait; i++) begin
      dmi_req_rdy = (i == req_wait);
      mid;
      chk("req_vld", dmi_req_vld, 1);
      chk("req_addr", dmi_req_addr, ea);
      chk("req_data", dmi_req_data, ed);
      chk("req_op", dmi_req_op, eo);
      chk("req_owner", owner, exp_win);
      chk("req_no_grant", m0_req_rdy | m1_req_rdy, 0);
      tick;
    end
    dmi_req_rdy = 0;
    for (int i = 0; i <= rsp_delay; i++) begin
      if (i == rsp_delay) begin
        dmi_rsp_vld = 1; dmi_rsp_data = rd; dmi_rsp_op = ro;
      end
      mid;
      chk("wait_rsp_vld", m0_rsp_vld | m1_rsp_vld | dmi_req_vld, 0);
      chk("wait_dmi_rsp_rdy", dmi_rsp_rdy, 1);
      chk("wait_no_grant", m0_req_rdy | m1_req_rdy, 0);
      tick;
    end
    dmi_rsp_vld = 0;
    for (int i = 0; i <= rsp_wait; i++) begin
      m0_rsp_rdy = (i == rsp_wait) && (exp_win == 0);
      m1_rsp_rdy = (i == rsp_wait) && (exp_win == 1);
      mid;
      chk("resp_vld_own", exp_win ? m1_rsp_vld : m0_rsp_vld, 1);
      chk("resp_vld_other", exp_win ? m0_rsp_vld : m1_rsp_vld, 0);
      chk("resp_data", exp_win ? m1_rsp_data : m0_rsp_data, rd);
      chk("resp_op", exp_win ? m1_rsp_op : m0_rsp_op, ro);
      chk("resp_dmi_rsp_rdy", dmi_rsp_rdy, 0);
      chk("resp_no_grant", m0_req_rdy | m1_req_rdy, 0);
      tick;
    end
    m0_rsp_rdy = 0; m1_rsp_rdy = 0;
  endtask

  // Grant requester `who` alone, reach WAIT, then pulse reset for one cycle.
  task automatic reset_in_wait(input int who);
    new_req(who);
    mid;
    chk("rw_grant", who ? m1_req_rdy : m0_req_rdy, 1);
    tick;
    pend[who] = 0;
    dmi_req_rdy = 1;
    tick;
    dmi_req_rdy = 0;
    mid;
    chk("rw_in_wait_busy", busy, 1);
    chk("rw_in_wait_owner", owner, who);
    tick;
    rst_n = 0;
    tick;
    rst_n = 1;
    rr_last = 1;
    mid;
    chk("rw_busy", busy, 0);
    chk("rw_owner", owner, 0);
    chk("rw_dmi_req_vld", dmi_req_vld, 0);
    chk("rw_dmi_rsp_rdy", dmi_rsp_rdy, 1);
    tick;
    dmi_rsp_vld = 1; dmi_rsp_data = 32'h5151_5151; dmi_rsp_op = 2'd0;
    tick;
    dmi_rsp_vld = 0;
    for (int i = 0; i < 3; i++) begin
      mid;
      chk("rw_no_rsp", m0_rsp_vld | m1_rsp_vld, 0);
      chk("rw_idle", busy, 0);
      tick;
    end
  endtask

  initial begin
    pend[0] = 0; pend[1] = 0;
    paddr[0] = '0; paddr[1] = '0; pdata[0] = '0; pdata[1] = '0; pop[0] = '0; pop[1] = '0;
    dmi_req_rdy = 0; dmi_rsp_vld = 0; dmi_rsp_data = '0; dmi_rsp_op = '0;
    m0_rsp_rdy = 0; m1_rsp_rdy = 0;
    rr_last = 1;

    tbl[0] = '{1'b1, 1'b0, 7'h10, 32'h8000_0001, 2'd1, 0, 0, 32'h1234_5678, 2'd0, 0, 0};
    tbl[1] = '{1'b0, 1'b1, 7'h22, 32'hCAFE_F00D, 2'd2, 5, 1, 32'h0BAD_F00D, 2'd0, 1, 1};
    tbl[2] = '{1'b1, 1'b0, 7'h7F, 32'hFFFF_FFFF, 2'd3, 0, 3, 32'h0000_0000, 2'd3, 2, 0};
    tbl[3] = '{1'b0, 1'b1, 7'h00, 32'h0000_0000, 2'd1, 2, 0, 32'hA5A5_A5A5, 2'd1, 0, 1};
    tbl[4] = '{1'b1, 1'b1, 7'h55, 32'h1357_9BDF, 2'd2, 1, 2, 32'h2468_ACE0, 2'd2, 1, 0};
    tbl[5] = '{1'b0, 1'b0, 7'h00, 32'h0000_0000, 2'd0, 0, 1, 32'hFEED_BEEF, 2'd1, 0, 1};

    do_reset;
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 2; i++) begin
        if ((i == 0 && tbl[r].v0) || (i == 1 && tbl[r].v1)) begin
          pend[i] = 1; paddr[i] = tbl[r].addr; pdata[i] = tbl[r].data; pop[i] = tbl[r].op;
        end
      end
      run_txn(tbl[r].exp_owner, tbl[r].req_wait, tbl[r].rsp_delay, tbl[r].rd, tbl[r].ro,
              tbl[r].rsp_wait, 1'b0);
    end

    // Both requesters continuously valid from reset: strict alternation.
    do_reset;
    new_req(0);
    new_req(1);
    for (int k = 0; k < 4; k++)
      run_txn(k % 2, 0, 0, $urandom, 2'($urandom_range(0, 3)), 0, 1'b1);

    // Randomized traffic against the transaction-level model.
    do_reset;
    for (int k = 0; k < 40; k++) begin
      for (int i = 0; i < 2; i++)
        if (!pend[i] && $urandom_range(0, 1) == 1) new_req(i);
      if (!pend[0] && !pend[1]) new_req(int'($urandom_range(0, 1)));
      run_txn(next_win(), int'($urandom_range(0, 3)), int'($urandom_range(0, 5)), $urandom,
              2'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 1'b0);
    end

    // Reset mid-WAIT: owned by m1 (owner must clear), then by m0 (rr pointer must reset).
    do_reset;
    reset_in_wait(1);
    new_req(0);
    run_txn(0, 0, 0, 32'h1111_2222, 2'd0, 0, 1'b0);
    reset_in_wait(0);
    new_req(0);
    new_req(1);
    run_txn(0, 0, 0, 32'h3333_4444, 2'd0, 0, 1'b0);
    run_txn(1, 0, 0, 32'h5555_6666, 2'd1, 0, 1'b0);

`ifdef DMI_ARB_TIMEOUT_EN
    // Silent DM: failure response after TO WAIT cycles, late response dropped.
    do_reset;
    new_req(0);
    tick;
    pend[0] = 0;
    dmi_req_rdy = 1;
    tick;
    dmi_req_rdy = 0;
    for (int i = 0; i < int'(TO); i++) begin
      mid;
      chk("to_wait_no_rsp", m0_rsp_vld, 0);
      chk("to_wait_busy", busy, 1);
      tick;
    end
    mid;
    chk("to_rsp_vld", m0_rsp_vld, 1);
    chk("to_rsp_op", m0_rsp_op, 2'b10);
    chk("to_rsp_data", m0_rsp_data, 0);
    chk("to_m1_quiet", m1_rsp_vld, 0);
    m0_rsp_rdy = 1;
    tick;
    m0_rsp_rdy = 0;
    dmi_rsp_vld = 1; dmi_rsp_data = 32'h7777_8888; dmi_rsp_op = 2'd0;
    mid;
    chk("to_late_idle", busy, 0);
    tick;
    dmi_rsp_vld = 0;
    for (int i = 0; i < 2; i++) begin
      mid;
      chk("to_late_dropped", m0_rsp_vld | m1_rsp_vld, 0);
      tick;
    end
    // Response on the final counted cycle beats the timeout.
    new_req(0);
    run_txn(0, 0, int'(TO) - 1, 32'hDEAD_BEEF, 2'd0, 0, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
